mcu_write_bridge: RTL and testbench

- Parametrised MCU-to-memory write bridge; replaces the single-slot MCU interface.
- Synchronises the asynchronous MCU register bus into the `clock` domain and keeps a programmable pixel address with optional auto-increment.
- Queues address+data pairs in a small write FIFO and drains them to the memory manager with a request/complete handshake.
- Adds readable CTRL/STATUS/address registers so firmware can stream pixels and poll for back-pressure.

---
 rtl/mcu_bridge_pkg.sv | 27 ++
 rtl/mcu_write_fifo.sv | 48 ++++
 rtl/mcu_write_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_mcu_write_bridge.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_bridge_pkg.sv
// Shared constants and types for the MCU-to-memory write bridge.
package mcu_bridge_pkg;

  localparam logic [2:0] REG_ADDR0  = 3'd0;
  localparam logic [2:0] REG_ADDR1  = 3'd1;
  localparam logic [2:0] REG_ADDR2  = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam int CTRL_AUTO_INC_BIT = 0;
  localparam int CTRL_CLR_OVF_BIT  = 7;
  localparam logic [7:0] CTRL_RESET = 8'h01;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_LEVEL_LSB = 3;
  localparam int STATUS_LEVEL_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/mcu_write_fifo.sv
// Synchronous write FIFO; pointers carry an extra MSB so full/empty need no extra flag.
module mcu_write_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           headData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic             doPush_s;
  logic             doPop_s;

  assign level    = wrPtr_r - rdPtr_r;
  assign full     = (level == PTR_W'(DEPTH));
  assign empty    = (wrPtr_r == rdPtr_r);
  assign doPush_s = push && (!full || pop);
  assign doPop_s  = pop && !empty;
  assign headData = mem_r[rdPtr_r[PTR_W-2:0]];

  // pointer advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
    end else begin
      if (doPush_s) wrPtr_r <= wrPtr_r + PTR_W'(1);
      if (doPop_s)  rdPtr_r <= rdPtr_r + PTR_W'(1);
    end
  end

  // storage write
  always_ff @(posedge clock) begin
    if (doPush_s) mem_r[wrPtr_r[PTR_W-2:0]] <= pushData;
  end

endmodule

// File: rtl/mcu_write_bridge.sv
// MCU register bus to memory-manager write bridge: synchronisers, register file,
// write FIFO and request/complete drain FSM.
module mcu_write_bridge
  import mcu_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          reset,
  input  logic                          clock,
  input  logic                          mcu_chip_select,
  input  logic                          mcu_write_enable_n,
  input  logic [2:0]                    mcu_register_select,
  input  logic [DATA_WIDTH-1:0]         mcu_data_in,
  output logic [DATA_WIDTH-1:0]         mcu_data_out,
  output logic                          mcu_data_oe,
  output logic [ADDR_WIDTH-1:0]         memory_address,
  output logic [DATA_WIDTH-1:0]         memory_write_data,
  output logic                          memory_write_request,
  input  logic                          memory_write_complete,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int EXT_W   = 3 * DATA_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] CTRL_STORE_MASK = ~(DATA_WIDTH'(1) << CTRL_CLR_OVF_BIT);

  function automatic logic [DATA_WIDTH-1:0] addrByte(input logic [ADDR_WIDTH-1:0] a, input int k);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a);
    return ext[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addrWrite(input logic [ADDR_WIDTH-1:0] a, input int k,
                                                      input logic [DATA_WIDTH-1:0] d);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a);
    ext[k*DATA_WIDTH +: DATA_WIDTH] = d;
    return ext[ADDR_WIDTH-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] strobeSync_r;
  logic [2:0]             selSync_r  [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]  dataSync_r [SYNC_STAGES];
  logic                   syncStrobe_s;
  logic                   strobePrev_r;
  logic [2:0]             selHold_r;
  logic [DATA_WIDTH-1:0]  dataHold_r;
  logic                   commit_s;

  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [DATA_WIDTH-1:0]  ctrl_r;
  logic [DATA_WIDTH-1:0]  lastData_r;
  logic                   overflow_r;

  logic                   pushReq_s;
  logic                   pushOk_s;
  logic                   fifoPush_s;
  logic                   pop_s;
  logic                   fifoFull_s;
  logic                   fifoEmpty_s;
  logic [ENTRY_W-1:0]     fifoHead_s;
  logic [$clog2(FIFO_DEPTH):0] fifoLevel_s;

  drain_state_t           state_r;
  drain_state_t           nextState_s;
  logic                   loadHead_s;
  logic                   requestNext_s;
  logic                   request_r;
  logic [ADDR_WIDTH-1:0]  memAddr_r;
  logic [DATA_WIDTH-1:0]  memData_r;

  logic [31:0]                 levelWide_s;
  logic [STATUS_LEVEL_W-1:0]   levelSat_s;
  logic [DATA_WIDTH-1:0]       statusByte_s;

  assign syncStrobe_s = strobeSync_r[SYNC_STAGES-1];
  assign commit_s     = strobePrev_r && !syncStrobe_s;
  assign pop_s        = (state_r == REQ) && memory_write_complete;
  assign pushReq_s    = commit_s && (selHold_r == REG_DATA);
  assign pushOk_s     = !fifoFull_s || pop_s;
  assign fifoPush_s   = pushReq_s && pushOk_s;

  // synchroniser chains for the asynchronous MCU bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobeSync_r <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        selSync_r[i]  <= 3'd0;
        dataSync_r[i] <= '0;
      end
    end else begin
      strobeSync_r  <= {strobeSync_r[SYNC_STAGES-2:0], mcu_chip_select && !mcu_write_enable_n};
      selSync_r[0]  <= mcu_register_select;
      dataSync_r[0] <= mcu_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        selSync_r[i]  <= selSync_r[i-1];
        dataSync_r[i] <= dataSync_r[i-1];
      end
    end
  end

  // hold the select/data seen while the synchronised strobe was high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobePrev_r <= 1'b0;
      selHold_r    <= 3'd0;
      dataHold_r   <= '0;
    end else begin
      strobePrev_r <= syncStrobe_s;
      if (syncStrobe_s) begin
        selHold_r  <= selSync_r[SYNC_STAGES-1];
        dataHold_r <= dataSync_r[SYNC_STAGES-1];
      end
    end
  end

  // register file updates on commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_r     <= '0;
      ctrl_r     <= DATA_WIDTH'(CTRL_RESET);
      lastData_r <= '0;
      overflow_r <= 1'b0;
    end else if (commit_s) begin
      case (selHold_r)
        REG_ADDR0: addr_r <= addrWrite(addr_r, 0, dataHold_r);
        REG_ADDR1: addr_r <= addrWrite(addr_r, 1, dataHold_r);
        REG_ADDR2: addr_r <= addrWrite(addr_r, 2, dataHold_r);
        REG_DATA: begin
          if (pushOk_s) begin
            lastData_r <= dataHold_r;
            if (ctrl_r[CTRL_AUTO_INC_BIT]) addr_r <= addr_r + ADDR_WIDTH'(1);
          end else begin
            overflow_r <= 1'b1;
          end
        end
        REG_CTRL: begin
          ctrl_r <= dataHold_r & CTRL_STORE_MASK;
          if (dataHold_r[CTRL_CLR_OVF_BIT]) overflow_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mcu_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifoPush_s),
    .pop      (pop_s),
    .pushData ({addr_r, dataHold_r}),
    .headData (fifoHead_s),
    .full     (fifoFull_s),
    .empty    (fifoEmpty_s),
    .level    (fifoLevel_s)
  );

  // drain state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // drain next-state
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    if (!fifoEmpty_s) nextState_s = REQ; else nextState_s = IDLE;
      REQ:     if (memory_write_complete) nextState_s = GAP; else nextState_s = REQ;
      GAP:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // drain output decode
  always_comb begin
    loadHead_s    = (state_r == IDLE) && !fifoEmpty_s;
    requestNext_s = (nextState_s == REQ);
  end

  // registered memory-side outputs; address/data only change when loading a new head
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      request_r <= 1'b0;
      memAddr_r <= '0;
      memData_r <= '0;
    end else begin
      request_r <= requestNext_s;
      if (loadHead_s) {memAddr_r, memData_r} <= fifoHead_s;
    end
  end

  // STATUS byte with the level field saturated to its width
  always_comb begin
    levelWide_s  = 32'(fifoLevel_s);
    if (levelWide_s > 32'd31) levelSat_s = 5'd31;
    else                      levelSat_s = levelWide_s[STATUS_LEVEL_W-1:0];
    statusByte_s = '0;
    statusByte_s[STATUS_FULL_BIT]  = fifoFull_s;
    statusByte_s[STATUS_EMPTY_BIT] = fifoEmpty_s;
    statusByte_s[STATUS_OVF_BIT]   = overflow_r;
    statusByte_s[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = levelSat_s;
  end

  // read mux uses the raw select so firmware sees data within the bus cycle
  always_comb begin
    case (mcu_register_select)
      REG_ADDR0:  mcu_data_out = addrByte(addr_r, 0);
      REG_ADDR1:  mcu_data_out = addrByte(addr_r, 1);
      REG_ADDR2:  mcu_data_out = addrByte(addr_r, 2);
      REG_DATA:   mcu_data_out = lastData_r;
      REG_CTRL:   mcu_data_out = ctrl_r;
      REG_STATUS: mcu_data_out = statusByte_s;
      default:    mcu_data_out = '0;
    endcase
  end

  assign mcu_data_oe          = mcu_chip_select && mcu_write_enable_n;
  assign memory_address       = memAddr_r;
  assign memory_write_data    = memData_r;
  assign memory_write_request = request_r;
  assign fifo_level           = fifoLevel_s;

endmodule

// File: tb/tb_mcu_write_bridge.sv
// Self-checking bench for mcu_write_bridge: register table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_mcu_write_bridge;

  logic        reset, clock;
  logic        cs, weN;
  logic [2:0]  regSel;
  logic [7:0]  dataIn, dataOut;
  logic        dataOe;
  logic [16:0] memAddr;
  logic [7:0]  memData;
  logic        memReq, memComplete;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  bit memStall = 1'b0;
  int memLatency = 0;
  bit forcePulse = 1'b0;

  logic [16:0] obsA[$];
  logic [7:0]  obsD[$];
  logic [16:0] expA[$];
  logic [7:0]  expD[$];

  int         mAddr;
  bit         mAuto;
  bit         mOvf;
  logic [7:0] mCtrl;
  logic [7:0] mLast;

  typedef struct {
    logic [2:0] wsel;
    logic [7:0] wdata;
    logic [2:0] rsel;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];

  mcu_write_bridge #(
    .ADDR_WIDTH(17), .DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)
  ) dut (
    .reset(reset), .clock(clock),
    .mcu_chip_select(cs), .mcu_write_enable_n(weN),
    .mcu_register_select(regSel), .mcu_data_in(dataIn),
    .mcu_data_out(dataOut), .mcu_data_oe(dataOe),
    .memory_address(memAddr), .memory_write_data(memData),
    .memory_write_request(memReq), .memory_write_complete(memComplete),
    .fifo_level(level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // memory manager: completes a request after memLatency extra cycles unless stalled
  initial begin
    int waitCnt = 0;
    memComplete = 1'b0;
    forever begin
      @(negedge clock);
      memComplete = 1'b0;
      if (forcePulse) begin
        memComplete = 1'b1;
        forcePulse = 1'b0;
      end else if (memReq && !memStall) begin
        if (waitCnt >= memLatency) begin
          memComplete = 1'b1;
          obsA.push_back(memAddr);
          obsD.push_back(memData);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (!memReq) begin
        waitCnt = 0;
      end
    end
  end

  task automatic mcuWrite(input logic [2:0] sel, input logic [7:0] d);
    @(negedge clock);
    cs = 1'b1; weN = 1'b0; regSel = sel; dataIn = d;
    repeat (4) @(negedge clock);
    cs = 1'b0; weN = 1'b1;
    regSel = 3'($urandom_range(0, 7)); dataIn = ~d;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic mcuRead(input logic [2:0] sel, output logic [7:0] d, output logic oe);
    @(negedge clock);
    cs = 1'b1; weN = 1'b1; regSel = sel;
    #1;
    d = dataOut; oe = dataOe;
    cs = 1'b0;
  endtask

  task automatic modelReset();
    mAddr = 0; mAuto = 1'b1; mOvf = 1'b0; mCtrl = 8'h01; mLast = 8'h00;
    expA.delete(); expD.delete(); obsA.delete(); obsD.delete();
  endtask

  // occupancy is what was accepted minus what the memory has completed
  task automatic modelWrite(input logic [2:0] sel, input logic [7:0] d);
    int pending;
    mcuWrite(sel, d);
    pending = expA.size() - obsA.size();
    case (sel)
      3'd0: mAddr = (mAddr & 32'h1FF00) | 32'(d);
      3'd1: mAddr = (mAddr & 32'h100FF) | (32'(d) << 8);
      3'd2: mAddr = (mAddr & 32'h0FFFF) | (32'(d[0]) << 16);
      3'd3: begin
        if (pending < 4) begin
          expA.push_back(17'(mAddr)); expD.push_back(d); mLast = d;
          if (mAuto) mAddr = (mAddr + 1) % 32'h20000;
        end else begin
          mOvf = 1'b1;
        end
      end
      3'd4: begin
        mAuto = d[0]; mCtrl = d & 8'h7F;
        if (d[7]) mOvf = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((level != 3'd0 || memReq) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  task automatic checkWrites(input string name);
    check({name, "_count"}, 32'(obsA.size()), 32'(expA.size()));
    for (int i = 0; i < obsA.size() && i < expA.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), 32'(obsA[i]), 32'(expA[i]));
      check($sformatf("%s_data%0d", name, i), 32'(obsD[i]), 32'(expD[i]));
    end
    expA.delete(); expD.delete(); obsA.delete(); obsD.delete();
  endtask

  task automatic checkModelRegs(input string name);
    logic [7:0] d;
    logic oe;
    mcuRead(3'd0, d, oe); check({name, "_addr0"}, 32'(d), mAddr & 32'hFF);
    mcuRead(3'd1, d, oe); check({name, "_addr1"}, 32'(d), (mAddr >> 8) & 32'hFF);
    mcuRead(3'd2, d, oe); check({name, "_addr2"}, 32'(d), (mAddr >> 16) & 32'h1);
    mcuRead(3'd3, d, oe); check({name, "_last"},  32'(d), 32'(mLast));
    mcuRead(3'd4, d, oe); check({name, "_ctrl"},  32'(d), 32'(mCtrl));
    mcuRead(3'd5, d, oe); check({name, "_ovf"},   32'(d[2]), 32'(mOvf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       oe;

    vecs[0]  = '{3'd0, 8'hFF, 3'd0, 8'hFF};
    vecs[1]  = '{3'd1, 8'h01, 3'd1, 8'h01};
    vecs[2]  = '{3'd2, 8'h03, 3'd2, 8'h01};
    vecs[3]  = '{3'd4, 8'h81, 3'd4, 8'h01};
    vecs[4]  = '{3'd4, 8'h80, 3'd4, 8'h00};
    vecs[5]  = '{3'd4, 8'h7E, 3'd4, 8'h7E};
    vecs[6]  = '{3'd2, 8'hFE, 3'd2, 8'h00};
    vecs[7]  = '{3'd0, 8'h5A, 3'd6, 8'h00};
    vecs[8]  = '{3'd4, 8'h01, 3'd5, 8'h02};
    vecs[9]  = '{3'd2, 8'h01, 3'd0, 8'h5A};
    vecs[10] = '{3'd5, 8'hFF, 3'd2, 8'h01};
    vecs[11] = '{3'd7, 8'h00, 3'd0, 8'h5A};
    vecs[12] = '{3'd0, 8'hFF, 3'd7, 8'h00};

    reset = 1'b1; cs = 1'b0; weN = 1'b1; regSel = 3'd0; dataIn = 8'h00;
    modelReset();
    repeat (3) @(negedge clock);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_req", 32'(memReq), 32'd0);
    check("rst_addr", 32'(memAddr), 32'd0);
    check("rst_data", 32'(memData), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mcuRead(3'd4, rd, oe); check("rst_ctrl", 32'(rd), 32'h01);
    mcuRead(3'd5, rd, oe); check("rst_status", 32'(rd), 32'h02);

    // register write/read-back table
    foreach (vecs[i]) begin
      modelWrite(vecs[i].wsel, vecs[i].wdata);
      mcuRead(vecs[i].rsel, rd, oe);
      check($sformatf("vec%0d_read", i), 32'(rd), 32'(vecs[i].exp));
      check($sformatf("vec%0d_oe", i), 32'(oe), 32'd1);
    end
    @(negedge clock);
    cs = 1'b0; weN = 1'b1; #1;
    check("oe_cs_low", 32'(dataOe), 32'd0);
    cs = 1'b1; weN = 1'b0; #1;
    check("oe_write_cycle", 32'(dataOe), 32'd0);
    cs = 1'b0; weN = 1'b1;

    // basic write: request one clock after the push clock, held while stalled
    memStall = 1'b1;
    modelWrite(3'd3, 8'h03);
    check("basic_req_early", 32'(memReq), 32'd0);
    check("basic_level", 32'(level), 32'd1);
    @(posedge clock); #1;
    check("basic_req", 32'(memReq), 32'd1);
    check("basic_addr", 32'(memAddr), 32'h101FF);
    check("basic_data", 32'(memData), 32'h03);
    repeat (5) @(negedge clock);
    check("basic_hold", {memReq, 7'd0, memAddr}, {1'b1, 7'd0, 17'h101FF});
    memStall = 1'b0;
    waitIdle(50);
    checkWrites("basic");

    // auto-increment burst into a stalled memory, then overflow
    memStall = 1'b1;
    modelWrite(3'd0, 8'h10); modelWrite(3'd1, 8'h00); modelWrite(3'd2, 8'h00);
    modelWrite(3'd4, 8'h01);
    for (int i = 0; i < 4; i++) modelWrite(3'd3, 8'hA0 + 8'(i));
    mcuRead(3'd5, rd, oe); check("burst_status", 32'(rd), 32'h21);
    check("burst_level", 32'(level), 32'd4);
    modelWrite(3'd3, 8'h55);
    mcuRead(3'd5, rd, oe); check("ovf_status", 32'(rd), 32'h25);
    mcuRead(3'd0, rd, oe); check("ovf_addr_held", 32'(rd), 32'h14);
    modelWrite(3'd4, 8'h81);
    mcuRead(3'd5, rd, oe); check("ovf_cleared", 32'(rd), 32'h21);
    mcuRead(3'd4, rd, oe); check("ovf_ctrl_kept", 32'(rd), 32'h01);
    memStall = 1'b0;
    waitIdle(100);
    check("burst_first_addr", 32'(obsA.size() > 0 ? obsA[0] : 17'h1FFFF), 32'h10);
    check("burst_last_data", 32'(obsD.size() > 3 ? obsD[3] : 8'h00), 32'hA3);
    checkWrites("burst");

    // address wrap, then auto-increment off
    modelWrite(3'd0, 8'hFF); modelWrite(3'd1, 8'hFF); modelWrite(3'd2, 8'h01);
    modelWrite(3'd3, 8'h11); modelWrite(3'd3, 8'h22);
    modelWrite(3'd4, 8'h00);
    modelWrite(3'd3, 8'h33); modelWrite(3'd3, 8'h44);
    waitIdle(100);
    check("wrap_second_addr", 32'(obsA.size() > 1 ? obsA[1] : 17'h1FFFF), 32'h00000);
    check("noinc_addr", 32'(obsA.size() > 3 ? obsA[3] : 17'h1FFFF), 32'h00001);
    checkWrites("wrap");

    // reset while a request is outstanding with entries queued
    modelWrite(3'd4, 8'h01);
    memStall = 1'b1;
    modelWrite(3'd3, 8'h61); modelWrite(3'd3, 8'h62); modelWrite(3'd3, 8'h63);
    @(posedge clock); #1;
    check("midreq_req", 32'(memReq), 32'd1);
    check("midreq_level", 32'(level), 32'd3);
    @(negedge clock);
    reset = 1'b1; #1;
    check("midreq_rst_req", 32'(memReq), 32'd0);
    check("midreq_rst_level", 32'(level), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    forcePulse = 1'b1;
    repeat (3) @(negedge clock);
    memStall = 1'b0;
    repeat (10) @(negedge clock);
    check("late_complete_req", 32'(memReq), 32'd0);
    check("late_complete_level", 32'(level), 32'd0);
    check("late_complete_writes", 32'(obsA.size()), 32'd0);
    checkModelRegs("post_reset");

    // randomized register traffic against the reference model
    for (int op = 0; op < 80; op++) begin
      int r;
      if ($urandom_range(0, 3) == 0) memStall = ~memStall;
      memLatency = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      modelWrite((r < 4) ? 3'd3 : 3'(r - 4), 8'($urandom_range(0, 255)));
      if (op % 4 == 3) checkModelRegs($sformatf("rnd%0d", op));
    end
    memStall = 1'b0;
    waitIdle(300);
    checkWrites("rnd");
    mcuRead(3'd5, rd, oe);
    check("rnd_final_status", 32'(rd), 32'(mOvf) * 32'd4 + 32'd2);
    checkModelRegs("rnd_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
